regfile_param: RTL

Parametrised successor to the team's 32x32 register file. It has:
- configurable data width and depth;
- two registered read ports;
- write-to-read bypass;
- optional hardwired zero register;
- asynchronous clear of all storage on reset;
- a sequential bulk-clear engine that zeroes every entry, one per cycle, on request.

It is the general-purpose operand store for the datapath and feature-extraction pipelines.

---
 rtl/regfile_if.sv | 27 ++
 rtl/regfile_param.sv | 112 +++++++++++
 2 files changed

// File: rtl/regfile_if.sv
// Bus bundle for regfile_param: write port, two read ports and the bulk-clear handshake.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] w_reg;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] r_reg1;
    logic [ADDR_W-1:0] r_reg2;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_drop;

    modport master (
        output reg_write, w_reg, w_data, r_reg1, r_reg2, clr_req,
        input  r_data1, r_data2, clr_busy, clr_done, wr_drop
    );

    modport slave (
        input  reg_write, w_reg, w_data, r_reg1, r_reg2, clr_req,
        output r_data1, r_data2, clr_busy, clr_done, wr_drop
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, optional write bypass,
// optional hardwired zero entry and a one-entry-per-cycle bulk-clear engine.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    regfile_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [DATA_W-1:0] r_data1_q, r_data1_d;
    logic [DATA_W-1:0] r_data2_q, r_data2_d;
    logic              busy;
    logic              done;
    logic              wr_hit;
    logic              wr_drop;

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear FSM next state; requests outside IDLE are deliberately dropped
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SWEEP);
        done = (state_q == DONE);
    end

    // Writes to the zero entry are accepted silently but never stored
    always_comb begin
        wr_hit  = bus.reg_write && !busy && !(ZERO_REG != 0 && bus.w_reg == '0);
        wr_drop = bus.reg_write && busy;
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_hit && bus.w_reg == ADDR_W'(i)) mem_d[i] = bus.w_data;
            if (busy && ptr_q == ADDR_W'(i))       mem_d[i] = '0;
        end
    end

    always_comb begin
        if (ZERO_REG != 0 && bus.r_reg1 == '0)
            r_data1_d = '0;
        else if (BYPASS != 0 && wr_hit && bus.w_reg == bus.r_reg1)
            r_data1_d = bus.w_data;
        else
            r_data1_d = mem_q[bus.r_reg1];

        if (ZERO_REG != 0 && bus.r_reg2 == '0)
            r_data2_d = '0;
        else if (BYPASS != 0 && wr_hit && bus.w_reg == bus.r_reg2)
            r_data2_d = bus.w_data;
        else
            r_data2_d = mem_q[bus.r_reg2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
            r_data1_q <= '0;
            r_data2_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
            r_data1_q <= r_data1_d;
            r_data2_q <= r_data2_d;
        end
    end

    assign bus.r_data1  = r_data1_q;
    assign bus.r_data2  = r_data2_q;
    assign bus.clr_busy = busy;
    assign bus.clr_done = done;
    assign bus.wr_drop  = wr_drop;
endmodule
